morty_muldiv_ctrl: RTL and testbench
====================================

Name: morty_muldiv_ctrl

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the execute-stage ALU.
- When the instruction in EX is an M-extension op, it holds EX with a stall request and runs a shift-add multiply or a restoring divide over several cycles.
- It then presents the 32-bit result for the EX/MEM register to capture.
- It honours the pipeline flush (kill) and the downstream MEM stall.

Parameters:
- BITS_PER_CYCLE, 1, quotient/product bits retired per iteration cycle; legal values 1, 2, 4.
- ITER, 32/BITS_PER_CYCLE, derived; number of iteration cycles. Not user-set.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  the EX instruction is a valid M-ext op; held high while EX is stalled.
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  in  32  operand a (dividend / multiplicand).
- rs2_i  in  32  operand b (divisor / multiplier).
- kill_i  in  1  flush of EX (trap, xret, branch); aborts the operation.
- mem_stall_i  in  1  EX/MEM register frozen this cycle.
- ex_stall_o  out  1  request to hold IF/ID/EX and bubble EX/MEM.
- busy_o  out  1  state is BUSY.
- done_o  out  1  result_o is valid this cycle.
- result_o  out  32  selected result word.

Behaviour:
- Async reset puts all outputs and state to 0: state IDLE, result_o=0, done_o=0, busy_o=0, ex_stall_o=0, counter=0.
- States: IDLE, BUSY, DONE. The counter is log2(ITER)+1 bits wide.
- IDLE with start_i=1 and kill_i=0:
  - Latch op_i, rs1_i, rs2_i, and operand sign flags; store absolute values for signed ops.
  - Normal op: go to BUSY with counter=0.
  - Special case: go straight to DONE.
- Special cases (single cycle, no iteration):
  - DIV/DIVU with rs2=0: quotient 0xFFFFFFFF.
  - REM/REMU with rs2=0: result = rs1.
  - DIV with 0x80000000 / 0xFFFFFFFF: result 0x80000000.
  - REM with 0x80000000 / 0xFFFFFFFF: result 0.
- BUSY: each cycle retires BITS_PER_CYCLE bits into a 64-bit accumulator. When counter reaches ITER-1, go to DONE on the next edge.
- Final sign correction is applied on the BUSY->DONE edge:
  - Product negated if exactly one signed operand is negative (MULHSU: only rs1 is signed).
  - Quotient negated on sign mismatch; remainder takes the dividend's sign.
- result_o selection:
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- result_o is registered and stable throughout DONE.
- Latency: start seen in IDLE at cycle N gives DONE at N+ITER+1 (N+33 for the default). Special cases reach DONE at N+1.
- ex_stall_o = start_i & ~kill_i & (state != DONE). It is combinational, so stall is high in cycle N itself.
- done_o = (state == DONE).
- DONE with mem_stall_i=1: hold DONE and result_o; done_o stays high.
- DONE with mem_stall_i=0: go to IDLE. EX advances this edge, and the next start_i belongs to the next instruction.
  - Back-to-back M-ops get a fresh IDLE cycle; there is no chaining.
- Operands are captured only at IDLE exit. Changes on rs1_i/rs2_i/op_i during BUSY/DONE are ignored.
- kill_i in any state (kill has priority over start):
  - Next state is IDLE; counter and accumulator are cleared.
  - ex_stall_o=0 in the kill cycle; done_o is never asserted for the killed op; result_o keeps its last value.
- start_i dropping while BUSY without kill_i (illegal): treat as kill.
- Reset mid-operation: immediate IDLE with all outputs 0; no partial result is visible.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD:
  - ex_stall_o high for 33 cycles.
  - done_o at N+33 with result_o=0xFFFFFFEB.
  - IDLE at N+34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Special cases, each with done_o at N+1:
  - DIVU 5 / 0 -> 0xFFFFFFFF.
  - REM 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- kill_i pulsed at BUSY counter=10:
  - Next cycle state is IDLE; done_o is never high.
  - A following MUL 3 x 4 gives 12 with full latency.
- mem_stall_i held high for 3 cycles on DONE entry:
  - done_o high for 4 cycles with result_o constant.
  - Rerun of the whole flow with an async rst_i pulse mid-BUSY: all outputs 0 immediately.

Source files
------------

// File: rtl/morty_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Shift-add multiply / restoring divide, BITS_PER_CYCLE bits retired per cycle.
module morty_muldiv_ctrl #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        kill_i,
  input  logic        mem_stall_i,
  output logic        ex_stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  localparam int ITER = 32 / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   result_q, result_d;

  logic          last_iter, abort_busy;
  logic          in_a_neg, in_b_neg, div_zero, div_ovf, special;
  logic [31:0]   in_abs_a, in_abs_b, special_res;
  logic [64:0]   work;
  logic [32:0]   sum, trial;
  logic [63:0]   step_acc, prod;
  logic [31:0]   quot, rem, final_res;

  assign last_iter  = (cnt_q == CW'(ITER - 1));
  assign abort_busy = kill_i | ~start_i;

  // Operand decode: signedness per funct3, absolute values and the
  // single-cycle divide corner cases that bypass the iteration.
  assign in_a_neg    = rs1_i[31] & (op_i == 3'b000 || op_i == 3'b001 || op_i == 3'b010 ||
                                    op_i == 3'b100 || op_i == 3'b110);
  assign in_b_neg    = rs2_i[31] & (op_i == 3'b000 || op_i == 3'b001 ||
                                    op_i == 3'b100 || op_i == 3'b110);
  assign in_abs_a    = in_a_neg ? -rs1_i : rs1_i;
  assign in_abs_b    = in_b_neg ? -rs2_i : rs2_i;
  assign div_zero    = op_i[2] & (rs2_i == 32'd0);
  assign div_ovf     = op_i[2] & ~op_i[0] & (rs1_i == 32'h8000_0000) & (rs2_i == 32'hFFFF_FFFF);
  assign special     = div_zero | div_ovf;
  assign special_res = div_zero ? (op_i[1] ? rs1_i : 32'hFFFF_FFFF)
                                : (op_i[1] ? 32'd0 : 32'h8000_0000);

  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    work  = {1'b0, acc_q};
    sum   = '0;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (!op_q[2]) begin
        // Multiply: hi += multiplicand when multiplier LSB set, then shift right.
        sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, a_q} : 33'd0);
        work = {sum, work[31:0]} >> 1;
      end else begin
        // Restoring divide: {rem, quot} shifts left, quotient bit enters at LSB.
        work  = {work[63:0], 1'b0};
        trial = work[64:32] - {1'b0, b_q};
        if (!trial[32]) work = {1'b0, trial[31:0], work[31:1], 1'b1};
      end
    end
    step_acc = work[63:0];
  end

  always_comb begin
    prod = (a_neg_q ^ b_neg_q) ? -step_acc : step_acc;
    quot = (a_neg_q ^ b_neg_q) ? -step_acc[31:0] : step_acc[31:0];
    rem  = a_neg_q ? -step_acc[63:32] : step_acc[63:32];
    case (op_q)
      3'b000:                 final_res = prod[31:0];
      3'b001, 3'b010, 3'b011: final_res = prod[63:32];
      3'b100, 3'b101:         final_res = quot;
      default:                final_res = rem;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && !kill_i) state_d = special ? DONE : BUSY;
      BUSY:    if (abort_busy) state_d = IDLE;
               else if (last_iter) state_d = DONE;
      DONE:    if (kill_i || !mem_stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ex_stall_o = start_i & ~kill_i & ~rst_i & (state_q != DONE);
    busy_o     = (state_q == BUSY);
    done_o     = (state_q == DONE);
    result_o   = result_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start_i && !kill_i) begin
        op_d    = op_i;
        a_d     = in_abs_a;
        b_d     = in_abs_b;
        a_neg_d = in_a_neg;
        b_neg_d = in_b_neg;
        cnt_d   = '0;
        acc_d   = {32'd0, op_i[2] ? in_abs_a : in_abs_b};
        if (special) result_d = special_res;
      end
      BUSY: if (abort_busy) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        acc_d = step_acc;
        if (last_iter) begin
          cnt_d    = '0;
          result_d = final_res;
        end
      end
      DONE: if (kill_i || !mem_stall_i) begin
        cnt_d = '0;
        acc_d = '0;
      end
      default: ;
    endcase
  end

  // Datapath state; result is cleared only by reset so a killed op leaves it untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_morty_muldiv_ctrl.sv
// Directed self-checking bench for morty_muldiv_ctrl: results, latency, stall,
// kill, MEM back-pressure and asynchronous reset.
module tb_morty_muldiv_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, kill_i, mem_stall_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic        ex_stall_o, busy_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                         DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  morty_muldiv_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .kill_i      (kill_i),
    .mem_stall_i (mem_stall_i),
    .ex_stall_o  (ex_stall_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Issues one M-op from IDLE at a negedge; scrambles operands after capture,
  // optionally holds MEM stalled in DONE, then retires the op and returns in IDLE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int mem_cycles);
    int lat;
    int stall_cnt;
    int done_cnt;
    op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
    #1;
    check({tag, " stall@N"}, 32'(ex_stall_o), 32'd1);
    stall_cnt = 1;
    lat = 0;
    do begin
      next_cycle();
      lat++;
      op_i = ~op; rs1_i = ~a; rs2_i = ~b;
      if (!done_o && ex_stall_o) stall_cnt++;
    end while (!done_o && lat < 100);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result_o, exp);
    check({tag, " stall cycles"}, 32'(stall_cnt), 32'(exp_lat));
    check({tag, " stall in DONE"}, 32'(ex_stall_o), 32'd0);
    done_cnt = 1;
    for (int i = 0; i < mem_cycles; i++) begin
      mem_stall_i = 1'b1;
      next_cycle();
      if (done_o) done_cnt++;
      check({tag, " held result"}, result_o, exp);
    end
    if (mem_cycles > 0) check({tag, " done cycles"}, 32'(done_cnt), 32'(mem_cycles + 1));
    mem_stall_i = 1'b0;
    start_i = 1'b0;
    next_cycle();
    check({tag, " idle done"}, 32'(done_o), 32'd0);
    check({tag, " idle busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int done_seen;
    rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0; mem_stall_i = 1'b0;
    op_i = '0; rs1_i = '0; rs2_i = '0;
    repeat (2) @(negedge clk_i);
    check("reset result", result_o, 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset stall", 32'(ex_stall_o), 32'd0);
    rst_i = 1'b0;
    next_cycle();

    run_op("MUL 7*-3",       MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("MULH min*min",   MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("MULHU max*max",  MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("MULHSU -1*2",    MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("DIV -7/2",       DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 0);
    run_op("REM -7/2",       REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("DIVU 100/7",     DIVU,   32'd100,        32'd7,         32'd14,        33, 0);
    run_op("REMU 100/7",     REMU,   32'd100,        32'd7,         32'd2,         33, 0);

    // Kill at BUSY counter=10 (cycle N+11): no DONE, result keeps 2.
    op_i = MUL; rs1_i = 32'd5; rs2_i = 32'd6; start_i = 1'b1;
    repeat (11) next_cycle();
    check("kill busy before", 32'(busy_o), 32'd1);
    kill_i = 1'b1;
    #1;
    check("kill stall", 32'(ex_stall_o), 32'd0);
    next_cycle();
    kill_i = 1'b0; start_i = 1'b0;
    check("kill idle busy", 32'(busy_o), 32'd0);
    check("kill result kept", result_o, 32'd2);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) done_seen++;
      next_cycle();
    end
    check("kill no done", 32'(done_seen), 32'd0);
    run_op("MUL 3*4 after kill", MUL, 32'd3, 32'd4, 32'd12, 33, 0);

    run_op("DIVU 5/0",       DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op("REM 5/0",        REM,    32'd5,          32'd0,         32'd5,         1, 0);
    run_op("DIV ovf",        DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("REM ovf",        REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 0);

    run_op("MULHU memstall", MULHU,  32'h0001_0000,  32'h0001_0000, 32'd1,         33, 3);

    // Async reset mid-BUSY clears everything without waiting for a clock edge.
    op_i = MUL; rs1_i = 32'd7; rs2_i = 32'hFFFF_FFFD; start_i = 1'b1;
    repeat (6) next_cycle();
    check("pre-reset busy", 32'(busy_o), 32'd1);
    check("pre-reset result", result_o, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("async rst result", result_o, 32'd0);
    check("async rst busy", 32'(busy_o), 32'd0);
    check("async rst done", 32'(done_o), 32'd0);
    check("async rst stall", 32'(ex_stall_o), 32'd0);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    next_cycle();
    run_op("MUL rerun", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("DIVU rerun", DIVU, 32'd100, 32'd7, 32'd14, 33, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
